mem_bus_arbiter: RTL and testbench

Shares the single native-interface peripheral bus (memory, gpio, prng, future UART) between NUM_MASTERS requesters, e.g. the picorv32 CPU and a DMA or debug master.
- Round-robin grant; each transaction is atomic from valid to ready.
- A watchdog completes any transaction whose slave never asserts ready, and flags it as a bus error.
- Sits between the masters and the address decoder/slave fabric.

---
 rtl/bus_pkg.sv | 21 ++
 rtl/rr_pick.sv | 35 +++
 rtl/mem_bus_arbiter.sv | 168 ++++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/bus_pkg.sv
// Shared native-bus definitions for the memory bus arbiter and its helpers.
// Holds field widths, the default error read data and the arbiter state enum.
package bus_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int STRB_W = 4;

    localparam logic [DATA_W-1:0] ERR_DATA_DEFAULT = 32'hDEAD_BEEF;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } bus_state_e;

    // Index width for n requesters; a single requester still needs one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin priority encoder: picks the first request at or
// after ptr_i in cyclic order. Kept generic so IRQ arbitration can reuse it.
module rr_pick import bus_pkg::*; #(
    parameter int N     = 2,
    parameter int IDX_W = idx_width(N)
) (
    input  logic [N-1:0]     req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [N-1:0]     gnt_o,
    output logic [IDX_W-1:0] idx_o,
    output logic             any_o
);

    int pos;

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        pos   = 0;
        for (int k = 0; k < N; k++) begin
            // ptr_i is always below N, so one subtraction wraps the position.
            pos = int'(ptr_i) + k;
            if (pos >= N) begin
                pos = pos - N;
            end
            if (!any_o && req_i[pos]) begin
                gnt_o[pos] = 1'b1;
                idx_o      = IDX_W'(pos);
                any_o      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter sharing the native peripheral bus between several
// masters, with a watchdog that completes stuck transactions as bus errors.
module mem_bus_arbiter import bus_pkg::*; #(
    parameter int                 NUM_MASTERS = 2,
    parameter int                 TIMEOUT     = 255,
    parameter logic [DATA_W-1:0]  ERR_DATA    = ERR_DATA_DEFAULT,
    localparam int                IDX_W       = idx_width(NUM_MASTERS)
) (
    input  logic                          clk,
    input  logic                          reset,

    input  logic [NUM_MASTERS-1:0]        m_valid,
    input  logic [NUM_MASTERS-1:0]        m_instr,
    input  logic [ADDR_W*NUM_MASTERS-1:0] m_addr,
    input  logic [DATA_W*NUM_MASTERS-1:0] m_wdata,
    input  logic [STRB_W*NUM_MASTERS-1:0] m_wstrb,
    output logic [NUM_MASTERS-1:0]        m_ready,
    output logic [DATA_W-1:0]             m_rdata,

    output logic                          s_valid,
    output logic                          s_instr,
    output logic [ADDR_W-1:0]             s_addr,
    output logic [DATA_W-1:0]             s_wdata,
    output logic [STRB_W-1:0]             s_wstrb,
    input  logic                          s_ready,
    input  logic [DATA_W-1:0]             s_rdata,

    output logic [NUM_MASTERS-1:0]        grant,
    output logic                          bus_error,
    output logic [IDX_W-1:0]              err_master,
    output bus_state_e                    dbg_state
);

    // Handshake: a master raises m_valid and holds it with stable fields until
    // it sees a one-cycle m_ready; the slave completes by raising s_ready while
    // s_valid is high. A transfer happens only on a cycle where both are high.

    localparam int TMR_W = $clog2(TIMEOUT + 1);

    bus_state_e               state_q, state_d;
    logic [NUM_MASTERS-1:0]   grant_q, grant_d;
    logic [IDX_W-1:0]         gidx_q, gidx_d;
    logic [IDX_W-1:0]         rr_ptr_q, rr_ptr_d;
    logic [TMR_W-1:0]         timer_q, timer_d;
    logic [IDX_W-1:0]         err_master_q, err_master_d;

    logic [NUM_MASTERS-1:0]   pick_gnt;
    logic [IDX_W-1:0]         pick_idx;
    logic                     pick_any;
    logic                     g_valid;
    logic                     timed_out;
    logic [IDX_W-1:0]         next_ptr;

    rr_pick #(
        .N     (NUM_MASTERS),
        .IDX_W (IDX_W)
    ) u_rr_pick (
        .req_i (m_valid),
        .ptr_i (rr_ptr_q),
        .gnt_o (pick_gnt),
        .idx_o (pick_idx),
        .any_o (pick_any)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            grant_q      <= '0;
            gidx_q       <= '0;
            rr_ptr_q     <= '0;
            timer_q      <= '0;
            err_master_q <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            gidx_q       <= gidx_d;
            rr_ptr_q     <= rr_ptr_d;
            timer_q      <= timer_d;
            err_master_q <= err_master_d;
        end
    end

    assign g_valid   = |(m_valid & grant_q);
    // timer_q counts BUSY cycles including the current one, so TIMEOUT=N
    // fires on the Nth BUSY cycle.
    assign timed_out = (timer_q == TMR_W'(TIMEOUT));
    assign next_ptr  = (int'(gidx_q) == NUM_MASTERS - 1) ? '0 : gidx_q + IDX_W'(1);

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        gidx_d       = gidx_q;
        rr_ptr_d     = rr_ptr_q;
        timer_d      = timer_q;
        err_master_d = err_master_q;
        s_valid      = 1'b0;
        m_ready      = '0;
        m_rdata      = s_rdata;
        bus_error    = 1'b0;
        err_master   = err_master_q;

        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    state_d = BUSY;
                    grant_d = pick_gnt;
                    gidx_d  = pick_idx;
                    timer_d = TMR_W'(1);
                end
            end
            BUSY: begin
                s_valid = g_valid;
                if (!g_valid) begin
                    // Master withdrew: abandon silently, fairness pointer kept.
                    state_d = IDLE;
                    grant_d = '0;
                    timer_d = '0;
                end else if (s_ready) begin
                    m_ready  = grant_q;
                    state_d  = IDLE;
                    grant_d  = '0;
                    timer_d  = '0;
                    rr_ptr_d = next_ptr;
                end else if (timed_out) begin
                    s_valid      = 1'b0;
                    m_ready      = grant_q;
                    m_rdata      = ERR_DATA;
                    bus_error    = 1'b1;
                    err_master   = gidx_q;
                    err_master_d = gidx_q;
                    state_d      = IDLE;
                    grant_d      = '0;
                    timer_d      = '0;
                    rr_ptr_d     = next_ptr;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
                timer_d = '0;
            end
        endcase
    end

    // Slave-side fields follow the registered grant only; idle drives zeros.
    always_comb begin
        s_instr = 1'b0;
        s_addr  = '0;
        s_wdata = '0;
        s_wstrb = '0;
        if (state_q == BUSY) begin
            for (int i = 0; i < NUM_MASTERS; i++) begin
                if (gidx_q == IDX_W'(i)) begin
                    s_instr = m_instr[i];
                    s_addr  = m_addr[ADDR_W*i +: ADDR_W];
                    s_wdata = m_wdata[DATA_W*i +: DATA_W];
                    s_wstrb = m_wstrb[STRB_W*i +: STRB_W];
                end
            end
        end
    end

    assign grant     = grant_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed self-checking bench for mem_bus_arbiter (2 masters, TIMEOUT=4).
// Inputs change 1ns after posedge; outputs are sampled on the negedge.
module tb_mem_bus_arbiter;
  import bus_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  m_valid, m_instr, m_ready, grant;
  logic [63:0] m_addr, m_wdata;
  logic [7:0]  m_wstrb;
  logic [31:0] m_rdata, s_addr, s_wdata, s_rdata;
  logic        s_valid, s_instr, s_ready, bus_error;
  logic [3:0]  s_wstrb;
  logic [0:0]  err_master;
  bus_state_e  dbg_state;

  int checks = 0;
  int errors = 0;

  mem_bus_arbiter #(.NUM_MASTERS(2), .TIMEOUT(4), .ERR_DATA(32'hDEAD_BEEF)) dut (
    .clk(clk), .reset(reset),
    .m_valid(m_valid), .m_instr(m_instr), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_wstrb(m_wstrb), .m_ready(m_ready), .m_rdata(m_rdata),
    .s_valid(s_valid), .s_instr(s_instr), .s_addr(s_addr), .s_wdata(s_wdata),
    .s_wstrb(s_wstrb), .s_ready(s_ready), .s_rdata(s_rdata),
    .grant(grant), .bus_error(bus_error), .err_master(err_master), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic set_m(input int i, input logic v, input logic instr, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] s);
    m_valid[i]         = v;
    m_instr[i]         = instr;
    m_addr[32*i +: 32]  = a;
    m_wdata[32*i +: 32] = d;
    m_wstrb[4*i +: 4]   = s;
  endtask

  task automatic slave(input logic rdy, input logic [31:0] d);
    s_ready = rdy;
    s_rdata = d;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    m_valid = '0; m_instr = '0; m_addr = '0; m_wdata = '0; m_wstrb = '0;
    slave(1'b0, 32'h0);
    tick(); tick();
    sample();
    checks++; if (grant !== 2'b00) begin errors++; $display("FAIL reset_grant: got %b want 00", grant); end
    checks++; if (s_valid !== 1'b0) begin errors++; $display("FAIL reset_s_valid: got %b want 0", s_valid); end
    checks++; if (m_ready !== 2'b00) begin errors++; $display("FAIL reset_m_ready: got %b want 00", m_ready); end
    checks++; if (bus_error !== 1'b0) begin errors++; $display("FAIL reset_bus_error: got %b want 0", bus_error); end
    checks++; if (err_master !== 1'b0) begin errors++; $display("FAIL reset_err_master: got %b want 0", err_master); end
    checks++; if (dbg_state !== IDLE) begin errors++; $display("FAIL reset_state: got %0d want IDLE", dbg_state); end
    tick();
    reset = 1'b0;
  endtask

  // rr_ptr=0: m0 first, then m1 even though m0 re-requests at once.
  task automatic test_contention();
    set_m(0, 1, 0, 32'h200, 32'h0, 4'h0);
    set_m(1, 1, 0, 32'h300, 32'h0, 4'h0);
    sample();
    checks++; if (grant !== 2'b00) begin errors++; $display("FAIL cont_latency: got %b want 00", grant); end
    tick(); sample();
    checks++; if (grant !== 2'b01) begin errors++; $display("FAIL cont_first_grant: got %b want 01", grant); end
    checks++; if (s_addr !== 32'h200) begin errors++; $display("FAIL cont_first_addr: got %h want 200", s_addr); end
    tick(); slave(1'b1, 32'h1111_0000); sample();
    checks++; if (m_ready !== 2'b01) begin errors++; $display("FAIL cont_first_ready: got %b want 01", m_ready); end
    checks++; if (m_rdata !== 32'h1111_0000) begin errors++; $display("FAIL cont_first_rdata: got %h want 11110000", m_rdata); end
    tick(); slave(1'b0, 32'h0); set_m(0, 1, 0, 32'h204, 32'h0, 4'h0); sample();
    checks++; if (grant !== 2'b00 || s_valid !== 1'b0) begin errors++; $display("FAIL cont_idle_gap: got grant %b s_valid %b want 00 0", grant, s_valid); end
    tick(); sample();
    checks++; if (grant !== 2'b10) begin errors++; $display("FAIL cont_second_grant: got %b want 10", grant); end
    checks++; if (s_addr !== 32'h300) begin errors++; $display("FAIL cont_second_addr: got %h want 300", s_addr); end
    tick(); slave(1'b1, 32'h2222_0000); sample();
    checks++; if (m_ready !== 2'b10) begin errors++; $display("FAIL cont_second_ready: got %b want 10", m_ready); end
    tick(); slave(1'b0, 32'h0); m_valid = 2'b00; sample();
    checks++; if (grant !== 2'b00) begin errors++; $display("FAIL cont_end_grant: got %b want 00", grant); end
  endtask

  task automatic test_single();
    tick(); set_m(0, 1, 0, 32'h100, 32'h0, 4'h0);
    tick(); sample();
    checks++; if (grant !== 2'b01) begin errors++; $display("FAIL single_grant: got %b want 01", grant); end
    checks++; if (s_valid !== 1'b1 || s_addr !== 32'h100 || s_wstrb !== 4'h0) begin errors++; $display("FAIL single_fields: got v %b a %h s %h want 1 100 0", s_valid, s_addr, s_wstrb); end
    checks++; if (m_ready !== 2'b00) begin errors++; $display("FAIL single_early_ready: got %b want 00", m_ready); end
    tick(); slave(1'b1, 32'h1234_5678); sample();
    checks++; if (m_ready !== 2'b01) begin errors++; $display("FAIL single_ready: got %b want 01", m_ready); end
    checks++; if (m_rdata !== 32'h1234_5678) begin errors++; $display("FAIL single_rdata: got %h want 12345678", m_rdata); end
    tick(); slave(1'b0, 32'h0); m_valid = 2'b00;
  endtask

  // rr_ptr=1 after the single master-0 access: m1 wins the double request.
  task automatic test_back_to_back();
    set_m(0, 1, 0, 32'h210, 32'h0, 4'h0);
    set_m(1, 1, 0, 32'h310, 32'h0, 4'h0);
    tick(); sample();
    checks++; if (grant !== 2'b10) begin errors++; $display("FAIL b2b_first_grant: got %b want 10", grant); end
    tick(); slave(1'b1, 32'h3333_0000); sample();
    checks++; if (m_ready !== 2'b10) begin errors++; $display("FAIL b2b_first_ready: got %b want 10", m_ready); end
    tick(); slave(1'b0, 32'h0); m_valid[1] = 1'b0;
    tick(); slave(1'b1, 32'h4444_0000); sample();
    checks++; if (grant !== 2'b01 || m_ready !== 2'b01) begin errors++; $display("FAIL b2b_second: got grant %b ready %b want 01 01", grant, m_ready); end
    tick(); slave(1'b0, 32'h0); m_valid = 2'b00;
  endtask

  task automatic test_write();
    set_m(0, 1, 1, 32'h400, 32'h5A5A_5A5A, 4'hF);
    set_m(1, 1, 0, 32'h500, 32'hA5A5_A5A5, 4'h3);
    tick(); sample();
    checks++; if (grant !== 2'b10) begin errors++; $display("FAIL wr_grant: got %b want 10", grant); end
    checks++; if (s_addr !== 32'h500 || s_wdata !== 32'hA5A5_A5A5 || s_wstrb !== 4'h3 || s_instr !== 1'b0) begin
      errors++; $display("FAIL wr_fields: got a %h d %h s %h i %b want 500 a5a5a5a5 3 0", s_addr, s_wdata, s_wstrb, s_instr); end
    tick(); sample();
    checks++; if (s_wdata !== 32'hA5A5_A5A5 || s_wstrb !== 4'h3) begin errors++; $display("FAIL wr_hold: got d %h s %h want a5a5a5a5 3", s_wdata, s_wstrb); end
    tick(); slave(1'b1, 32'h0); sample();
    checks++; if (m_ready !== 2'b10) begin errors++; $display("FAIL wr_ready: got %b want 10", m_ready); end
    tick(); slave(1'b0, 32'h0); m_valid[1] = 1'b0;
    tick(); slave(1'b1, 32'h0); sample();
    checks++; if (grant !== 2'b01 || s_instr !== 1'b1 || s_wstrb !== 4'hF || s_wdata !== 32'h5A5A_5A5A) begin
      errors++; $display("FAIL wr_m0_fields: got g %b i %b s %h d %h want 01 1 f 5a5a5a5a", grant, s_instr, s_wstrb, s_wdata); end
    tick(); slave(1'b0, 32'h0); m_valid = 2'b00;
  endtask

  task automatic test_timeout();
    set_m(1, 1, 0, 32'h600, 32'h0, 4'h0);
    slave(1'b0, 32'h0BAD_F00D);
    tick(); sample();
    checks++; if (s_valid !== 1'b1 || m_ready !== 2'b00 || bus_error !== 1'b0) begin
      errors++; $display("FAIL to_busy1: got v %b r %b e %b want 1 00 0", s_valid, m_ready, bus_error); end
    tick(); tick(); sample();
    checks++; if (m_ready !== 2'b00 || bus_error !== 1'b0) begin errors++; $display("FAIL to_busy3: got r %b e %b want 00 0", m_ready, bus_error); end
    tick(); sample();
    checks++; if (m_ready !== 2'b10) begin errors++; $display("FAIL to_ready: got %b want 10", m_ready); end
    checks++; if (m_rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL to_rdata: got %h want deadbeef", m_rdata); end
    checks++; if (bus_error !== 1'b1 || err_master !== 1'b1) begin errors++; $display("FAIL to_error: got e %b m %b want 1 1", bus_error, err_master); end
    checks++; if (s_valid !== 1'b0) begin errors++; $display("FAIL to_s_valid: got %b want 0", s_valid); end
    tick(); m_valid = 2'b00; sample();
    checks++; if (grant !== 2'b00 || bus_error !== 1'b0 || err_master !== 1'b1) begin
      errors++; $display("FAIL to_after: got g %b e %b m %b want 00 0 1", grant, bus_error, err_master); end
  endtask

  task automatic test_coincide();
    set_m(0, 1, 0, 32'h700, 32'h0, 4'h0);
    slave(1'b0, 32'h0);
    tick(); tick(); tick(); tick();
    slave(1'b1, 32'hCAFE_F00D); sample();
    checks++; if (m_ready !== 2'b01 || m_rdata !== 32'hCAFE_F00D) begin
      errors++; $display("FAIL co_complete: got r %b d %h want 01 cafef00d", m_ready, m_rdata); end
    checks++; if (bus_error !== 1'b0 || err_master !== 1'b1) begin errors++; $display("FAIL co_no_error: got e %b m %b want 0 1", bus_error, err_master); end
    tick(); slave(1'b0, 32'h0); m_valid = 2'b00;
  endtask

  // rr_ptr=1 before reset; afterwards master 0 must win.
  task automatic test_reset_mid();
    set_m(1, 1, 0, 32'h800, 32'h0, 4'h0);
    tick(); sample();
    checks++; if (grant !== 2'b10) begin errors++; $display("FAIL rm_grant: got %b want 10", grant); end
    tick(); reset = 1'b1; sample();
    checks++; if (m_ready !== 2'b00) begin errors++; $display("FAIL rm_no_ready: got %b want 00", m_ready); end
    tick(); reset = 1'b0; set_m(0, 1, 0, 32'h900, 32'h0, 4'h0); sample();
    checks++; if (grant !== 2'b00 || s_valid !== 1'b0 || m_ready !== 2'b00) begin
      errors++; $display("FAIL rm_cleared: got g %b v %b r %b want 00 0 00", grant, s_valid, m_ready); end
    checks++; if (err_master !== 1'b0 || dbg_state !== IDLE) begin errors++; $display("FAIL rm_state: got m %b st %0d want 0 IDLE", err_master, dbg_state); end
    tick(); slave(1'b1, 32'h0); sample();
    checks++; if (grant !== 2'b01 || m_ready !== 2'b01) begin errors++; $display("FAIL rm_m0_first: got g %b r %b want 01 01", grant, m_ready); end
    tick(); slave(1'b0, 32'h0); m_valid = 2'b00;
  endtask

  task automatic test_drop();
    set_m(1, 1, 0, 32'hA00, 32'h0, 4'h0);
    tick(); sample();
    checks++; if (grant !== 2'b10 || s_valid !== 1'b1) begin errors++; $display("FAIL dr_grant: got g %b v %b want 10 1", grant, s_valid); end
    tick(); m_valid[1] = 1'b0; sample();
    checks++; if (s_valid !== 1'b0 || m_ready !== 2'b00 || bus_error !== 1'b0) begin
      errors++; $display("FAIL dr_abort: got v %b r %b e %b want 0 00 0", s_valid, m_ready, bus_error); end
    tick(); slave(1'b1, 32'h5555_0000);
    set_m(0, 1, 0, 32'hB00, 32'h0, 4'h0); set_m(1, 1, 0, 32'hA04, 32'h0, 4'h0); sample();
    checks++; if (grant !== 2'b00 || m_ready !== 2'b00) begin errors++; $display("FAIL dr_idle_ready: got g %b r %b want 00 00", grant, m_ready); end
    tick(); sample();
    checks++; if (grant !== 2'b10 || m_ready !== 2'b10) begin errors++; $display("FAIL dr_ptr_kept: got g %b r %b want 10 10", grant, m_ready); end
    tick(); slave(1'b0, 32'h0); m_valid = 2'b00;
  endtask

  initial begin
    test_reset();
    test_contention();
    test_single();
    test_back_to_back();
    test_write();
    test_timeout();
    test_coincide();
    test_reset_mid();
    test_drop();
    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
